prefetch_queue: RTL and testbench
=================================

Name: prefetch_queue

Overview:
- Instruction-byte prefetcher sitting directly upstream of the CPU core.
- Streams sequential bytes from synchronous block RAM ahead of the core's PC, so the core never stalls for a memory read between fetch and operand bytes.
- Delivers each byte with its address through a valid/ready handshake.
- Restarts from a new address on flush (reset vector, later branches and jumps).

Parameters:
- DEPTH, 4, queue entries; power of two, range 2..16.
- ADDR_W, 16, address width.
- DATA_W, 8, byte width.
- RESET_PC, 16'h0000, first fetch address after reset.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset; when low, state clears on the next posedge.
- mem_addr  out  ADDR_W  read address to block RAM.
- mem_rd  out  1  read strobe; the addressed data returns on mem_din exactly one cycle later.
- mem_din  in  DATA_W  read data from block RAM.
- flush  in  1  discard all queued and in-flight bytes; restart fetching at flush_pc.
- flush_pc  in  ADDR_W  restart address; sampled when flush=1.
- byte_out  out  DATA_W  head-of-queue byte.
- byte_pc  out  ADDR_W  address of byte_out.
- byte_valid  out  1  head entry valid.
- byte_ready  in  1  core accepts the head byte.
- level  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (reset=0 at posedge):
  - fetch_pc=RESET_PC; queue empty; inflight=0; kill=0.
  - Outputs: mem_rd=0, mem_addr=RESET_PC, byte_valid=0, byte_out=0, byte_pc=0, level=0.
  - Reset mid-operation drops everything, including the in-flight return.
- States:
  - RUN: normal fetching.
  - FLUSH: a one-cycle bubble after flush. No issue occurs in FLUSH. Next state is always RUN.
  - Transitions: flush=1 in any state -> FLUSH. Reset -> RUN.
- Issue rule (RUN only):
  - Condition: mem_rd=1 when level + inflight < DEPTH.
  - Accounting: inflight counts the request whose data returns next cycle.
  - Action on issue: mem_addr=fetch_pc; then fetch_pc+1, wrapping modulo 2^ADDR_W (FFFF -> 0000).
- Return: in the cycle after a mem_rd, mem_din is written at the tail with tag = issued address, unless kill=1. kill is set by flush and cleared the next cycle.
- Pop: on byte_valid && byte_ready, the head advances at the posedge.
- Simultaneous push and pop: level unchanged. Push to a full queue never happens; issue accounting guarantees it. Pop from empty is ignored.
- Flush priority:
  - byte_valid is gated low combinationally in the flush cycle, so no handshake completes then.
  - Queue cleared; fetch_pc=flush_pc; pending return killed.
  - The first issue of flush_pc happens in the cycle after FLUSH.
- Latency (no bypass):
  - reset released at cycle 0 -> mem_rd at cycle 0, data written at the end of cycle 1, byte_valid=1 at cycle 2.
  - flush at cycle t -> issue at t+1, byte_valid at t+3.
- Steady state: one byte per cycle when byte_ready is held high.
- byte_out and byte_pc hold their value while byte_valid=1 and byte_ready=0.

Optional Feature:
- Macro: PREFETCH_BYPASS_EN.
- Defined:
  - When the queue is empty and a non-killed return arrives, mem_din and its tag drive byte_out/byte_pc with byte_valid=1 in the same cycle.
  - If byte_ready=1, the byte is not written into the queue.
  - First-byte latency drops by one cycle: after reset, valid at cycle 1; after a flush at t, valid at t+2.
- Undefined: all data passes through the queue, with the latencies given above.

Decomposition:
- Package cpu_pkg holds: ADDR_W, DATA_W, the RESET_PC default, and the state encoding constants PQ_RUN and PQ_FLUSH.
- One natural sub-module: sync_fifo.
  - Parameterised by DEPTH and width (DATA_W+ADDR_W).
  - Provides push, pop, clear, level, head.
  - Uses the same synchronous active-low reset.

Test Plan:
1. Reset low 3 cycles, then high, with byte_ready=1 and memory holding mem[i]=i^8'h5A -> byte_valid first at cycle 2; byte_pc 0,1,2,3 with byte_out 5A,5B,58,59, then one byte per cycle.
2. byte_ready=0 after reset -> mem_rd stops after 4 issues; level=4; byte_out=5A is stable. Then raise byte_ready -> 4 bytes drain in order and issue resumes at pc 4.
3. flush=1 with flush_pc=16'h0200 while the queue is full and a read is in flight -> byte_valid=0 that cycle; no stale byte appears; the first delivered byte_pc is 0200, valid at t+3.
4. flush_pc=16'hFFFE -> byte_pc sequence FFFE, FFFF, 0000, 0001.
5. Random byte_ready at 50% for 1000 bytes -> byte_pc strictly sequential, no drop or duplicate, level never exceeds 4.
6. With PREFETCH_BYPASS_EN defined: flush to 0x0010 at t with byte_ready=1 -> byte_valid at t+2 with byte_pc=0010; level stays 0 during a continuous drain.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-side constants: bus widths, reset vector and prefetcher state encoding.
package cpu_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  typedef enum logic {
    PQ_RUN   = 1'b0,
    PQ_FLUSH = 1'b1
  } pq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with clear. The head reads as zero while the FIFO is empty.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_CNT) || do_pop);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers and count decide what is visible.
  always_ff @(posedge clk) begin
    if (reset && !clear && do_push) mem[wr_ptr] <= din;
  end

  assign head  = (count != '0) ? mem[rd_ptr] : '0;
  assign level = count;

endmodule

// File: rtl/prefetch_queue.sv
// Sequential instruction-byte prefetcher in front of the core, fed from synchronous block RAM.
// Build option: define PREFETCH_BYPASS_EN to hand a returning byte straight to the core when the queue is empty.
module prefetch_queue #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_rd,
  input  logic [DATA_W-1:0]      mem_din,
  input  logic                   flush,
  input  logic [ADDR_W-1:0]      flush_pc,
  output logic [DATA_W-1:0]      byte_out,
  output logic [ADDR_W-1:0]      byte_pc,
  output logic                   byte_valid,
  input  logic                   byte_ready,
  output logic [$clog2(DEPTH):0] level
);

  import cpu_pkg::*;

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int TW = DATA_W + ADDR_W;
  localparam logic [LW:0] DEPTH_V = (LW+1)'(DEPTH);

  pq_state_t         state_q;
  pq_state_t         state_d;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic              kill;
  logic              issue;
  logic              ret_valid;
  logic              push;
  logic              pop;
  logic [LW:0]       occupancy;
  logic [LW-1:0]     fifo_level;
  logic [TW-1:0]     fifo_head;

  // The flush cycle itself is the bubble; FLUSH marks the following cycle so any late return is dropped.
  always_comb begin
    state_d = PQ_RUN;
    kill    = (state_q == PQ_FLUSH);
    if (flush) state_d = PQ_FLUSH;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= PQ_RUN;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else begin
      state_q  <= state_d;
      inflight <= issue;
      if (issue) inflight_pc <= fetch_pc;
      if (flush)      fetch_pc <= flush_pc;
      else if (issue) fetch_pc <= fetch_pc + 1'b1;
    end
  end

  // Counting the in-flight read guarantees its data always finds a free slot.
  assign occupancy = {1'b0, fifo_level} + {{LW{1'b0}}, inflight};
  assign issue     = reset && !flush && (occupancy < DEPTH_V);
  assign mem_rd    = issue;
  assign mem_addr  = fetch_pc;
  assign ret_valid = inflight && !kill && !flush;

`ifdef PREFETCH_BYPASS_EN
  logic bypass;

  assign bypass     = ret_valid && (fifo_level == '0);
  assign byte_valid = !flush && ((fifo_level != '0) || bypass);
  assign byte_out   = bypass ? mem_din : fifo_head[DATA_W-1:0];
  assign byte_pc    = bypass ? inflight_pc : fifo_head[TW-1:DATA_W];
  assign push       = ret_valid && !(bypass && byte_ready);
`else
  assign byte_valid = !flush && (fifo_level != '0);
  assign byte_out   = fifo_head[DATA_W-1:0];
  assign byte_pc    = fifo_head[TW-1:DATA_W];
  assign push       = ret_valid;
`endif

  assign pop   = byte_valid && byte_ready;
  assign level = fifo_level;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (flush),
    .din   ({inflight_pc, mem_din}),
    .head  (fifo_head),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue: reset timing table, back-pressure, flushes, address wrap and random drain.
module tb_prefetch_queue;

`ifdef PREFETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic        ready;
    logic        exp_valid;
    logic [15:0] exp_pc;
    logic [7:0]  exp_out;
    logic [2:0]  exp_level;
    logic [15:0] exp_addr;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_din = 8'h00;
  logic        flush = 1'b0;
  logic [15:0] flush_pc = 16'h0000;
  logic [7:0]  byte_out;
  logic [15:0] byte_pc;
  logic        byte_valid;
  logic        byte_ready = 1'b0;
  logic [2:0]  level;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          delivered = 0;
  int          rd_cnt = 0;
  int          max_level = 0;
  logic        sb_en = 1'b0;
  logic        track_level = 1'b0;
  logic [23:0] sb_q[$];
  logic [23:0] exp_entry;
  vec_t        tbl[12];

  prefetch_queue #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_din    (mem_din),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .byte_out   (byte_out),
    .byte_pc    (byte_pc),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .level      (level)
  );

  always #5 clk = ~clk;

  // Block RAM model: mem[i] = i ^ 5A, data one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_din <= mem_addr[7:0] ^ 8'h5A;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic rdy, input logic fl, input logic [15:0] fpc);
    byte_ready = rdy;
    flush      = fl;
    flush_pc   = fpc;
  endtask

  task automatic do_reset();
    apply_stimulus(1'b0, 1'b0, 16'h0000);
    reset = 1'b0;
    repeat (3) next_cycle();
    reset = 1'b1;
  endtask

  function automatic void push_expected(input logic [15:0] start, input int n);
    logic [15:0] pc;
    pc = start;
    for (int i = 0; i < n; i++) begin
      sb_q.push_back({pc, pc[7:0] ^ 8'h5A});
      pc = pc + 16'h0001;
    end
  endfunction

  // Scoreboard: every accepted byte must match the next expected address/data.
  always @(negedge clk) begin
    if (sb_en && byte_valid && byte_ready) begin
      if (sb_q.size() == 0) begin
        total_cnt++;
        $display("[TB] FAIL unexpected_byte: got pc %h, expected no byte", byte_pc);
      end else begin
        exp_entry = sb_q.pop_front();
        check_output("sb_byte_pc", 32'(byte_pc), 32'(exp_entry[23:8]));
        check_output("sb_byte_out", 32'(byte_out), 32'(exp_entry[7:0]));
      end
      delivered++;
    end
    if (track_level && int'(level) > max_level) max_level = int'(level);
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 12; i++) begin
      tbl[i].ready    = 1'b1;
      tbl[i].exp_addr = 16'(i);
      if (i >= LAT) begin
        tbl[i].exp_valid = 1'b1;
        tbl[i].exp_pc    = 16'(i - LAT);
        tbl[i].exp_out   = 8'(i - LAT) ^ 8'h5A;
        tbl[i].exp_level = (LAT == 2) ? 3'd1 : 3'd0;
      end else begin
        tbl[i].exp_valid = 1'b0;
        tbl[i].exp_pc    = 16'h0000;
        tbl[i].exp_out   = 8'h00;
        tbl[i].exp_level = 3'd0;
      end
    end

    // Reset state while reset is held low.
    reset = 1'b0;
    next_cycle();
    @(negedge clk);
    check_output("rst_mem_rd", 32'(mem_rd), 32'd0);
    check_output("rst_mem_addr", 32'(mem_addr), 32'h0000);
    check_output("rst_byte_valid", 32'(byte_valid), 32'd0);
    check_output("rst_byte_out", 32'(byte_out), 32'h00);
    check_output("rst_byte_pc", 32'(byte_pc), 32'h0000);
    check_output("rst_level", 32'(level), 32'd0);
    next_cycle();
    next_cycle();
    reset = 1'b1;

    // Cycle-by-cycle timing after reset release, byte_ready held high.
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(tbl[i].ready, 1'b0, 16'h0000);
      @(negedge clk);
      check_output($sformatf("t1_valid_c%0d", i), 32'(byte_valid), 32'(tbl[i].exp_valid));
      check_output($sformatf("t1_pc_c%0d", i), 32'(byte_pc), 32'(tbl[i].exp_pc));
      check_output($sformatf("t1_out_c%0d", i), 32'(byte_out), 32'(tbl[i].exp_out));
      check_output($sformatf("t1_level_c%0d", i), 32'(level), 32'(tbl[i].exp_level));
      check_output($sformatf("t1_rd_c%0d", i), 32'(mem_rd), 32'd1);
      check_output($sformatf("t1_addr_c%0d", i), 32'(mem_addr), 32'(tbl[i].exp_addr));
      next_cycle();
    end

    // Back-pressure: four issues fill the queue, head holds, then drain resumes fetching at 4.
    do_reset();
    rd_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_rd) rd_cnt++;
      next_cycle();
    end
    check_output("t2_issue_count", 32'(rd_cnt), 32'd4);
    @(negedge clk);
    check_output("t2_level_full", 32'(level), 32'd4);
    check_output("t2_valid", 32'(byte_valid), 32'd1);
    check_output("t2_head_pc", 32'(byte_pc), 32'h0000);
    check_output("t2_head_out", 32'(byte_out), 32'h5A);
    next_cycle();
    @(negedge clk);
    check_output("t2_head_stable", 32'(byte_out), 32'h5A);
    check_output("t2_no_issue_full", 32'(mem_rd), 32'd0);
    next_cycle();
    sb_q.delete();
    push_expected(16'h0000, 64);
    delivered = 0;
    sb_en = 1'b1;
    byte_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check_output("t2_resume_rd", 32'(mem_rd), 32'd1);
        check_output("t2_resume_addr", 32'(mem_addr), 32'h0004);
      end
      next_cycle();
    end
    check_output("t2_drained", 32'(delivered), 32'd8);
    sb_en = 1'b0;

    // Flush with a full-ish queue and a read in flight.
    do_reset();
    repeat (4) next_cycle();
    apply_stimulus(1'b1, 1'b1, 16'h0200);
    sb_q.delete();
    push_expected(16'h0200, 8);
    delivered = 0;
    sb_en = 1'b1;
    @(negedge clk);
    check_output("t3_level_before", 32'(level), 32'd3);
    check_output("t3_valid_gated", 32'(byte_valid), 32'd0);
    check_output("t3_no_issue", 32'(mem_rd), 32'd0);
    next_cycle();
    apply_stimulus(1'b1, 1'b0, 16'h0000);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check_output($sformatf("t3_valid_t%0d", k), 32'(byte_valid), 32'(k >= LAT + 1));
      if (k == 1) begin
        check_output("t3_first_rd", 32'(mem_rd), 32'd1);
        check_output("t3_first_addr", 32'(mem_addr), 32'h0200);
      end
      next_cycle();
    end
    check_output("t3_delivered", 32'(delivered), 32'(6 - LAT));

    // Flush near the top of the address space: FFFE, FFFF, 0000, 0001, ...
    apply_stimulus(1'b1, 1'b1, 16'hFFFE);
    sb_q.delete();
    push_expected(16'hFFFE, 16);
    delivered = 0;
    @(negedge clk);
    check_output("t4_valid_gated", 32'(byte_valid), 32'd0);
    next_cycle();
    apply_stimulus(1'b1, 1'b0, 16'h0000);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      next_cycle();
    end
    check_output("t4_delivered", 32'(delivered), 32'(10 - LAT));

    // Random back-pressure over 1000 bytes.
    apply_stimulus(1'b0, 1'b1, 16'h1234);
    sb_q.delete();
    push_expected(16'h1234, 1000);
    delivered = 0;
    max_level = 0;
    next_cycle();
    flush = 1'b0;
    track_level = 1'b1;
    for (int c = 0; c < 5000 && delivered < 1000; c++) begin
      byte_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      next_cycle();
    end
    byte_ready = 1'b0;
    track_level = 1'b0;
    check_output("t5_delivered", 32'(delivered), 32'd1000);
    check_output("t5_sb_empty", 32'(sb_q.size()), 32'd0);
    check_output("t5_level_le_depth", 32'(max_level <= 4), 32'd1);
    sb_en = 1'b0;

`ifdef PREFETCH_BYPASS_EN
    // Bypass: first byte after a flush arrives at t+2 and the queue stays empty while draining.
    apply_stimulus(1'b1, 1'b1, 16'h0010);
    sb_q.delete();
    push_expected(16'h0010, 16);
    delivered = 0;
    sb_en = 1'b1;
    next_cycle();
    apply_stimulus(1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    check_output("t6_valid_t1", 32'(byte_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    check_output("t6_valid_t2", 32'(byte_valid), 32'd1);
    check_output("t6_pc_t2", 32'(byte_pc), 32'h0010);
    next_cycle();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_output($sformatf("t6_level_%0d", k), 32'(level), 32'd0);
      next_cycle();
    end
    sb_en = 1'b0;
    byte_ready = 1'b0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
